// File: rtl/k2red_pkg.sv
// Shared constants, width helpers and the k-value helper for the K2-RED reduction pipeline.
package k2red_pkg;

    localparam int LAT = 6;
    localparam int KW  = 64;

    typedef enum logic {
        K_ADD = 1'b0,
        K_SUB = 1'b1
    } ksign_e;

    function automatic int iw_of(input int w);
        return 2 * w + 4;
    endfunction

    function automatic int sw_of(input int w);
        return $clog2(2 * w);
    endfunction

    // k = 2^k1 +/- 2^k2, used only to check that a written modulus matches its k/m fields.
    function automatic logic [KW-1:0] k_of(input logic [7:0] k1, input logic [7:0] k2, input ksign_e ks);
        logic [KW-1:0] p1;
        logic [KW-1:0] p2;
        p1 = {{(KW-1){1'b0}}, 1'b1} << k1;
        p2 = {{(KW-1){1'b0}}, 1'b1} << k2;
        if (ks == K_SUB) begin
            k_of = p1 - p2;
        end else begin
            k_of = p1 + p2;
        end
    endfunction

endpackage

// File: rtl/k2red_if.sv
// Configuration, operand and result handshake bundle for k2red_pipe.
interface k2red_if #(
    parameter int W     = 32,
    parameter int TAG_W = 8,
    parameter int SW    = 6
);
    logic             cfg_we;
    logic [W-1:0]     cfg_q;
    logic [SW-1:0]    cfg_k1;
    logic [SW-1:0]    cfg_k2;
    logic             cfg_ksub;
    logic [SW-1:0]    cfg_m;
    logic             cfg_ready;
    logic             cfg_err;
    logic             in_valid;
    logic             in_ready;
    logic [2*W-1:0]   in_a;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_c;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output cfg_we, cfg_q, cfg_k1, cfg_k2, cfg_ksub, cfg_m, in_valid, in_a, in_tag, out_ready,
        input  cfg_ready, cfg_err, in_ready, out_valid, out_c, out_tag
    );

    modport slave (
        input  cfg_we, cfg_q, cfg_k1, cfg_k2, cfg_ksub, cfg_m, in_valid, in_a, in_tag, out_ready,
        output cfg_ready, cfg_err, in_ready, out_valid, out_c, out_tag
    );
endinterface

// File: rtl/k2red_split.sv
// Registered split of a signed word at bit m: arithmetic high part and masked low part.
module k2red_split #(
    parameter int W_IN = 68,
    parameter int SW   = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en_i,
    input  logic signed [W_IN-1:0] x_i,
    input  logic [SW-1:0]          m_i,
    input  logic [W_IN-1:0]        mask_i,
    output logic signed [W_IN-1:0] hi_o,
    output logic [W_IN-1:0]        lo_o
);
    logic signed [W_IN-1:0] hi_q;
    logic [W_IN-1:0]        lo_q;
    logic signed [W_IN-1:0] hi_d;
    logic [W_IN-1:0]        lo_d;

    // Next-state split of the incoming word.
    always_comb begin
        hi_d = x_i >>> m_i;
        lo_d = x_i & mask_i;
    end

    // Split register, advancing only with the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (en_i) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;
endmodule

// File: rtl/k2red_pipe.sv
// Six-stage back-pressurable K2-RED reduction: C = k^2*A mod q for q = k*2^m + 1.
module k2red_pipe
    import k2red_pkg::*;
#(
    parameter int W     = 32,
    parameter int TAG_W = 8,
    parameter int SW    = sw_of(W),
    parameter int IW    = iw_of(W)
) (
    input logic   clk,
    input logic   rst_n,
    k2red_if.slave bus
);
    localparam int PW = 128;

    logic [W-1:0]     q_q;
    logic [SW-1:0]    k1_q;
    logic [SW-1:0]    k2_q;
    ksign_e           ksub_q;
    logic [SW-1:0]    m_q;
    logic [W-1:0]     mask_q;
    logic             err_q;
    logic [LAT:0]     v_q;
    logic [TAG_W-1:0] tag_q [LAT+1];
    logic [2*W-1:0]   a_q;
    logic signed [IW-1:0] c1_q;
    logic signed [IW-1:0] c2_q;
    logic signed [IW-1:0] r1_q;
    logic [W-1:0]     out_c_q;

    logic adv_s, in_ready_s, cfg_ready_s, in_acc_s, cfg_bad_s;
    logic [PW-1:0]        qk_s;
    logic [W:0]           msh_s;
    logic [W-1:0]         mask_d;
    logic signed [IW-1:0] hi1_s, hi2_s, fold1_d, fold2_d, qx_s, r1_d, r2_s;
    logic [IW-1:0]        lo1_s, lo2_s, mask_ext_s;

    function automatic logic signed [IW-1:0] fold(input logic [IW-1:0] l, input logic signed [IW-1:0] h,
                                                  input logic [SW-1:0] k1, input logic [SW-1:0] k2,
                                                  input ksign_e ks);
        logic signed [IW-1:0] t1;
        logic signed [IW-1:0] t2;
        t1 = $signed(l << k1);
        t2 = $signed(l << k2);
        if (ks == K_SUB) begin
            fold = t1 - t2 - h;
        end else begin
            fold = t1 + t2 - h;
        end
    endfunction

    function automatic logic signed [IW-1:0] corr(input logic signed [IW-1:0] x, input logic signed [IW-1:0] qx);
        if (x[IW-1]) begin
            corr = x + qx;
        end else if (x >= qx) begin
            corr = x - qx;
        end else begin
            corr = x;
        end
    endfunction

    // Handshake and config legality decode.
    always_comb begin
        adv_s       = !v_q[LAT] || bus.out_ready;
        in_ready_s  = adv_s && !bus.cfg_we;
        in_acc_s    = bus.in_valid && in_ready_s;
        cfg_ready_s = (v_q == '0) && !bus.in_valid;
        qk_s = (PW'(k_of(8'(bus.cfg_k1), 8'(bus.cfg_k2), ksign_e'(bus.cfg_ksub))) << bus.cfg_m)
             + {{(PW-1){1'b0}}, 1'b1};
        cfg_bad_s = (bus.cfg_k2 >= bus.cfg_k1) || (bus.cfg_m == '0) || (int'(bus.cfg_m) >= W)
                 || (bus.cfg_k1 >= bus.cfg_m) || (qk_s != PW'(bus.cfg_q));
        msh_s  = ({{W{1'b0}}, 1'b1} << bus.cfg_m) - {{W{1'b0}}, 1'b1};
        mask_d = msh_s[W-1:0];
    end

    // Folds and corrections between the stage registers.
    always_comb begin
        mask_ext_s = {{(IW-W){1'b0}}, mask_q};
        qx_s       = $signed({{(IW-W){1'b0}}, q_q});
        fold1_d    = fold(lo1_s, hi1_s, k1_q, k2_q, ksub_q);
        fold2_d    = fold(lo2_s, hi2_s, k1_q, k2_q, ksub_q);
        r1_d       = corr(c2_q, qx_s);
        r2_s       = corr(r1_q, qx_s);
    end

    // Run-time modulus configuration; the mask is derived once here rather than per operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= '0;
            k1_q   <= '0;
            k2_q   <= '0;
            ksub_q <= K_ADD;
            m_q    <= '0;
            mask_q <= '0;
            err_q  <= 1'b0;
        end else if (bus.cfg_we && cfg_ready_s) begin
            if (cfg_bad_s) begin
                err_q <= 1'b1;
            end else begin
                q_q    <= bus.cfg_q;
                k1_q   <= bus.cfg_k1;
                k2_q   <= bus.cfg_k2;
                ksub_q <= ksign_e'(bus.cfg_ksub);
                m_q    <= bus.cfg_m;
                mask_q <= mask_d;
            end
        end
    end

    // Stage valids, tags and datapath registers all move together on adv.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q     <= '0;
            a_q     <= '0;
            c1_q    <= '0;
            c2_q    <= '0;
            r1_q    <= '0;
            out_c_q <= '0;
            for (int i = 0; i <= LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else if (adv_s) begin
            v_q      <= {v_q[LAT-1:0], in_acc_s};
            tag_q[0] <= bus.in_tag;
            for (int i = 1; i <= LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            a_q     <= bus.in_a;
            c1_q    <= fold1_d;
            c2_q    <= fold2_d;
            r1_q    <= r1_d;
            out_c_q <= r2_s[W-1:0];
        end
    end

    k2red_split #(.W_IN(IW), .SW(SW)) u_split1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (adv_s),
        .x_i    ($signed({{(IW-2*W){1'b0}}, a_q})),
        .m_i    (m_q),
        .mask_i (mask_ext_s),
        .hi_o   (hi1_s),
        .lo_o   (lo1_s)
    );

    k2red_split #(.W_IN(IW), .SW(SW)) u_split2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (adv_s),
        .x_i    (c1_q),
        .m_i    (m_q),
        .mask_i (mask_ext_s),
        .hi_o   (hi2_s),
        .lo_o   (lo2_s)
    );

    assign bus.in_ready  = in_ready_s;
    assign bus.cfg_ready = cfg_ready_s;
    assign bus.cfg_err   = err_q;
    assign bus.out_valid = v_q[LAT];
    assign bus.out_c     = out_c_q;
    assign bus.out_tag   = tag_q[LAT];
endmodule

// File: tb/tb_k2red_pipe.sv
// Scoreboard bench for k2red_pipe: driver pushes expected results, a monitor pops and compares.
module tb_k2red_pipe;
    localparam int W = 32;
    localparam int TAG_W = 8;
    localparam int SW = 6;

    typedef struct packed {
        logic [W-1:0]     c;
        logic [TAG_W-1:0] t;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    k2red_if #(.W(W), .TAG_W(TAG_W), .SW(SW)) bus ();

    k2red_pipe #(.W(W), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    logic [TAG_W-1:0] tag_cnt = '0;
    int   rdy_mode = 0;
    // model of the configuration the bench believes is loaded
    logic [63:0] mq;
    int   mk1, mk2, mksub;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] ref_red(input logic [63:0] a);
        logic [127:0] k, kk;
        k = (128'd1 << mk1);
        if (mksub != 0) k = k - (128'd1 << mk2);
        else            k = k + (128'd1 << mk2);
        kk = (k * k) % {64'd0, mq};
        return W'((kk * {64'd0, a}) % {64'd0, mq});
    endfunction

    // output ready pattern generator
    initial begin
        logic [3:0] patv;
        int p;
        patv = 4'b1001;
        p = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: bus.out_ready = 1'b1;
                1: begin bus.out_ready = patv[p]; p = (p + 1) % 4; end
                2: bus.out_ready = ($urandom_range(3) != 0);
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // monitor
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 64'(bus.out_c), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_c", 64'(bus.out_c), 64'(e.c));
                chk("out_tag", 64'(bus.out_tag), 64'(e.t));
            end
        end
    end

    task automatic send(input logic [63:0] a, input logic [W-1:0] expc);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a = a;
        bus.in_tag = tag_cnt;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back('{c: expc, t: tag_cnt});
                ok = 1'b1;
            end
            @(posedge clk); #1;
            if (ok) break;
        end
        bus.in_valid = 1'b0;
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
        tag_cnt = tag_cnt + 8'd1;
    endtask

    task automatic send_lat(input logic [63:0] a, input logic [W-1:0] expc);
        int n;
        send(a, expc);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            n++;
            if (bus.out_valid) break;
        end
        chk("latency", 64'(n), 64'd6);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 5000 && sb.size() != 0; i++) @(posedge clk);
        chk("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic cfg_write(input logic [W-1:0] q, input int k1, input int k2, input int ks, input int m);
        bus.cfg_q = q;
        bus.cfg_k1 = SW'(k1);
        bus.cfg_k2 = SW'(k2);
        bus.cfg_ksub = ks[0];
        bus.cfg_m = SW'(m);
        bus.cfg_we = 1'b1;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
    endtask

    task automatic set_model(input logic [63:0] q, input int k1, input int k2, input int ks);
        mq = q; mk1 = k1; mk2 = k2; mksub = ks;
    endtask

    task automatic rand_run(input int n);
        logic [63:0] a;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(4) == 0) begin @(posedge clk); #1; end
            a = {$urandom, $urandom} % (mq * mq);
            send(a, ref_red(a));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cfg_we = 1'b0; bus.cfg_q = '0; bus.cfg_k1 = '0; bus.cfg_k2 = '0;
        bus.cfg_ksub = 1'b0; bus.cfg_m = '0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_tag = '0;
        #23;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_c", 64'(bus.out_c), 64'd0);
        chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
        chk("rst_cfg_err", 64'(bus.cfg_err), 64'd0);
        chk("rst_cfg_ready", 64'(bus.cfg_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Dilithium directed
        cfg_write(32'd8380417, 10, 0, 1, 13);
        set_model(64'd8380417, 10, 0, 1);
        chk("cfg_err_dil", 64'(bus.cfg_err), 64'd0);
        send_lat(64'd0, 32'd0);
        send_lat(64'd1, 32'd1046529);
        send_lat(64'd8380417, 32'd0);
        send_lat(64'd8380416 * 64'd8380416, 32'd1046529);
        drain();

        // add-mode directed
        cfg_write(32'd12289, 1, 0, 0, 12);
        set_model(64'd12289, 1, 0, 0);
        chk("cfg_err_add", 64'(bus.cfg_err), 64'd0);
        send_lat(64'd1, 32'd9);
        send_lat(64'd12288, 32'd12280);
        send_lat(64'd12289 * 64'd12288, 32'd0);
        drain();

        // stream with 1,0,0,1 back-pressure
        rdy_mode = 1;
        for (int i = 0; i < 20; i++) begin
            logic [63:0] a;
            a = {$urandom, $urandom} % (mq * mq);
            send(a, ref_red(a));
        end
        drain();

        // config write while data is held is ignored
        rdy_mode = 3;
        send(64'd1, 32'd9);
        repeat (8) @(posedge clk);
        #1;
        chk("cfg_ready_busy", 64'(bus.cfg_ready), 64'd0);
        cfg_write(32'd8380417, 10, 0, 1, 13);
        chk("cfg_err_ignored", 64'(bus.cfg_err), 64'd0);
        rdy_mode = 0;
        drain();
        send(64'd12288, 32'd12280);
        drain();

        // illegal config rejected, old config kept
        cfg_write(32'd12289, 0, 1, 0, 12);
        chk("cfg_err_illegal", 64'(bus.cfg_err), 64'd1);
        send(64'd1, 32'd9);
        drain();

        // randomized runs under both configurations
        rdy_mode = 2;
        rand_run(1500);
        drain();
        rdy_mode = 0;
        cfg_write(32'd8380417, 10, 0, 1, 13);
        set_model(64'd8380417, 10, 0, 1);
        rdy_mode = 2;
        rand_run(1500);
        rdy_mode = 0;
        drain();
        chk("cfg_err_sticky", 64'(bus.cfg_err), 64'd1);

        // asynchronous reset with operands in flight
        rdy_mode = 3;
        for (int i = 0; i < 4; i++) send(64'(i + 5), ref_red(64'(i + 5)));
        for (int i = 0; i < 20 && !bus.out_valid; i++) begin @(posedge clk); #1; end
        chk("inflight_valid", 64'(bus.out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_drop", 64'(bus.out_valid), 64'd0);
        chk("rst_cfg_err2", 64'(bus.cfg_err), 64'd0);
        sb.delete();
        rdy_mode = 0;
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int stale;
            stale = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (bus.out_valid) stale++;
            end
            chk("no_stale", 64'(stale), 64'd0);
        end
        @(posedge clk); #1;
        cfg_write(32'd12289, 1, 0, 0, 12);
        set_model(64'd12289, 1, 0, 0);
        send_lat(64'd12288, 32'd12280);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
